mem_access_stage: RTL

//  Parametrised MEM pipeline stage between EX and WB. Supports a variable-latency memory through a req/ack handshake.

---
 rtl/mem_access_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: single-transaction req/ack memory port, stalls EX in WAIT.
// Optional abort-on-timeout when MA_TIMEOUT_EN is defined.
module mem_access_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned CTRL_W   = 4,
  parameter logic [CTRL_W-1:0] OP_LOAD  = 4'b1101,
  parameter logic [CTRL_W-1:0] OP_STORE = 4'b1110,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ex,
  input  logic [CTRL_W-1:0] control_ex,
  input  logic [DATA_W-1:0] result_ex,
  input  logic [DATA_W-1:0] reg_data_ex,
  input  logic [IDX_W-1:0]  dest_reg_index_ex,
  input  logic              dest_reg_write_en_ex,
  output logic              stall_ma,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              valid_ma,
  output logic [CTRL_W-1:0] control_ma,
  output logic [DATA_W-1:0] result_ma,
  output logic [DATA_W-1:0] data_ma,
  output logic [IDX_W-1:0]  dest_reg_index_ma,
  output logic              dest_reg_write_en_ma,
  output logic              err_ma
);

  generate
    if (ADDR_W > DATA_W || TIMEOUT < 1) begin : g_bad_cfg
      $error("mem_access_stage: bad parameters");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state;

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] res_q;
  logic [IDX_W-1:0]  idx_q;
  logic              we_q;

  logic is_load;
  logic is_store;

  assign is_load  = control_ex == OP_LOAD;
  assign is_store = control_ex == OP_STORE;
  assign stall_ma = state == S_WAIT;

`ifdef MA_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;
`endif

  // Accept ops in IDLE, retire on ack (or timeout) in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      mem_req              <= 1'b0;
      mem_we               <= 1'b0;
      mem_addr             <= '0;
      mem_wdata            <= '0;
      valid_ma             <= 1'b0;
      control_ma           <= '0;
      result_ma            <= '0;
      data_ma              <= '0;
      dest_reg_index_ma    <= '0;
      dest_reg_write_en_ma <= 1'b0;
      err_ma               <= 1'b0;
      ctrl_q               <= '0;
      res_q                <= '0;
      idx_q                <= '0;
      we_q                 <= 1'b0;
`ifdef MA_TIMEOUT_EN
      cnt                  <= '0;
`endif
    end else begin
      valid_ma <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (valid_ex && (is_load || is_store)) begin
            ctrl_q    <= control_ex;
            res_q     <= result_ex;
            idx_q     <= dest_reg_index_ex;
            we_q      <= dest_reg_write_en_ex;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= result_ex[ADDR_W-1:0];
            mem_wdata <= is_store ? reg_data_ex : '0;
            state     <= S_WAIT;
`ifdef MA_TIMEOUT_EN
            cnt       <= '0;
`endif
          end else if (valid_ex) begin
            valid_ma             <= 1'b1;
            control_ma           <= control_ex;
            result_ma            <= result_ex;
            data_ma              <= '0;
            dest_reg_index_ma    <= dest_reg_index_ex;
            dest_reg_write_en_ma <= dest_reg_write_en_ex;
            err_ma               <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            valid_ma             <= 1'b1;
            control_ma           <= ctrl_q;
            result_ma            <= res_q;
            data_ma              <= (ctrl_q == OP_LOAD) ?
                                    mem_rdata : '0;
            dest_reg_index_ma    <= idx_q;
            dest_reg_write_en_ma <= we_q;
            err_ma               <= 1'b0;
            mem_req              <= 1'b0;
            mem_we               <= 1'b0;
            mem_wdata            <= '0;
            state                <= S_IDLE;
          end
`ifdef MA_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            valid_ma             <= 1'b1;
            control_ma           <= ctrl_q;
            result_ma            <= res_q;
            data_ma              <= '0;
            dest_reg_index_ma    <= idx_q;
            dest_reg_write_en_ma <= 1'b0;
            err_ma               <= 1'b1;
            mem_req              <= 1'b0;
            mem_we               <= 1'b0;
            mem_wdata            <= '0;
            state                <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
